// File: rtl/router_merge.sv
// router_merge: two-channel weighted round-robin merger. Drains the router's
// VC0/VC1 output FIFOs into one tagged stream {valid, src, data}, honours a
// downstream pause and counts delivered words per channel.
module router_merge #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WEIGHT0 = 4,
  parameter int unsigned WEIGHT1 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic              fifo0_empty,
  output logic              fifo0_pop,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              fifo1_empty,
  output logic              fifo1_pop,
  input  logic              pause_in,
  output logic [DATA_W+1:0] out_word,
  output logic              out_valid,
  output logic              active_ch,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam logic [3:0] QUANTUM0 = 4'(WEIGHT0 - 1);
  localparam logic [3:0] QUANTUM1 = 4'(WEIGHT1 - 1);

  state_t     state, state_nx;
  logic [3:0] burst_cnt, burst_nx;
  logic       last_ch, last_nx;
  logic       rd_pend, rd_src;

  logic       cur, cur_empty, oth_empty;
  logic [3:0] quantum;

  assign active_ch = (state == SERVE1);

  // Arbitration state register; last_ch resets to 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_ch   <= 1'b1;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
      last_ch   <= last_nx;
    end
  end

  // Next-state and pop strobes; both SERVE states share one branch keyed on
  // the granted channel (cur) with the other channel's FIFO as the fallback.
  always_comb begin
    state_nx  = state;
    burst_nx  = burst_cnt;
    last_nx   = last_ch;
    fifo0_pop = 1'b0;
    fifo1_pop = 1'b0;
    cur       = (state == SERVE1);
    cur_empty = cur ? fifo1_empty : fifo0_empty;
    oth_empty = cur ? fifo0_empty : fifo1_empty;
    quantum   = cur ? QUANTUM1 : QUANTUM0;
    case (state)
      IDLE: begin
        if (!fifo0_empty && (fifo1_empty || last_ch)) begin
          state_nx = SERVE0;
          burst_nx = '0;
        end else if (!fifo1_empty) begin
          state_nx = SERVE1;
          burst_nx = '0;
        end
      end
      SERVE0, SERVE1: begin
        if (!pause_in) begin
          if (!cur_empty) begin
            fifo0_pop = !cur;
            fifo1_pop = cur;
            if (burst_cnt == quantum) begin
              last_nx  = cur;
              burst_nx = '0;
              if (!oth_empty) begin
                if (cur) state_nx = SERVE0;
                else     state_nx = SERVE1;
              end
            end else begin
              burst_nx = burst_cnt + 4'd1;
            end
          end else begin
            last_nx  = cur;
            burst_nx = '0;
            if (oth_empty)  state_nx = IDLE;
            else if (cur)   state_nx = SERVE0;
            else            state_nx = SERVE1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        burst_nx = '0;
      end
    endcase
  end

  // Read pipeline: remember each pop, then capture the FIFO data a cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend   <= 1'b0;
      rd_src    <= 1'b0;
      out_word  <= '0;
      out_valid <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      rd_pend   <= fifo0_pop | fifo1_pop;
      rd_src    <= fifo1_pop;
      out_valid <= rd_pend;
      if (rd_pend) begin
        out_word <= {1'b1, rd_src, (rd_src ? fifo1_data : fifo0_data)};
        if (rd_src) cnt1 <= cnt1 + 16'd1;
        else        cnt0 <= cnt0 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_router_merge.sv
// tb_router_merge: self-checking bench for router_merge with bench-side FIFO
// models, a per-cycle scoreboard and a weighted round-robin schedule model.
module tb_router_merge;

  localparam int W0    = 4;
  localparam int W1    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fifo0_data, fifo1_data;
  logic        fifo0_empty, fifo1_empty, fifo0_pop, fifo1_pop;
  logic        pause_in = 1'b0;
  logic [9:0]  out_word;
  logic        out_valid, active_ch;
  logic [15:0] cnt0, cnt1;

  logic [7:0]  mem0 [DEPTH];
  logic [7:0]  mem1 [DEPTH];
  int          head0 = 0, head1 = 0, tail0 = 0, tail1 = 0;

  int          checks = 0, failures = 0;
  int          cyc = 0;
  bit          rec_en = 1'b0;
  logic [9:0]  rec_word [$];
  int          rec_cyc [$];

  bit          h1v = 1'b0, h2v = 1'b0, h1s = 1'b0, h2s = 1'b0;
  logic [7:0]  h1d = '0, h2d = '0;
  logic [9:0]  eword = '0;
  logic [15:0] ecnt0 = '0, ecnt1 = '0;

  router_merge #(.DATA_W(8), .WEIGHT0(W0), .WEIGHT1(W1)) dut (
    .clk(clk), .reset(reset),
    .fifo0_data(fifo0_data), .fifo0_empty(fifo0_empty), .fifo0_pop(fifo0_pop),
    .fifo1_data(fifo1_data), .fifo1_empty(fifo1_empty), .fifo1_pop(fifo1_pop),
    .pause_in(pause_in), .out_word(out_word), .out_valid(out_valid),
    .active_ch(active_ch), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  assign fifo0_empty = (head0 == tail0);
  assign fifo1_empty = (head1 == tail1);

  // Bench FIFOs: read data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo0_pop && head0 != tail0) begin
      fifo0_data <= mem0[head0 % DEPTH];
      head0 <= head0 + 1;
    end
    if (fifo1_pop && head1 != tail1) begin
      fifo1_data <= mem1[head1 % DEPTH];
      head1 <= head1 + 1;
    end
  end

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle scoreboard: a pop in cycle t must surface as a tagged word in t+2.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      h1v = 0; h2v = 0; eword = '0; ecnt0 = '0; ecnt1 = '0;
      check(!fifo0_pop && !fifo1_pop, "rst_pops", {fifo1_pop, fifo0_pop}, 0);
      check(out_valid == 1'b0, "rst_valid", out_valid, 0);
      check(out_word == '0, "rst_word", out_word, 0);
      check(cnt0 == '0 && cnt1 == '0, "rst_cnt", {cnt1, cnt0}, 0);
    end else begin
      check(!(fifo0_pop && fifo1_pop), "one_pop", {fifo1_pop, fifo0_pop}, 0);
      if (pause_in)
        check(!fifo0_pop && !fifo1_pop, "pause_pop", {fifo1_pop, fifo0_pop}, 0);
      if (fifo0_pop) check(!fifo0_empty, "pop0_empty", fifo0_empty, 0);
      if (fifo1_pop) check(!fifo1_empty, "pop1_empty", fifo1_empty, 0);
      if (fifo0_pop || fifo1_pop)
        check(active_ch == fifo1_pop, "active_ch", active_ch, fifo1_pop);
      if (h2v) begin
        eword = {1'b1, h2s, h2d};
        if (h2s) ecnt1 = ecnt1 + 16'd1;
        else     ecnt0 = ecnt0 + 16'd1;
      end
      check(out_valid == h2v, "out_valid", out_valid, h2v);
      check(out_word == eword, "out_word", out_word, eword);
      check(cnt0 == ecnt0, "cnt0", cnt0, ecnt0);
      check(cnt1 == ecnt1, "cnt1", cnt1, ecnt1);
      if (rec_en && out_valid) begin
        rec_word.push_back(out_word);
        rec_cyc.push_back(cyc);
      end
      h2v = h1v; h2s = h1s; h2d = h1d;
      h1v = fifo0_pop || fifo1_pop;
      h1s = fifo1_pop;
      h1d = fifo1_pop ? mem1[head1 % DEPTH] : mem0[head0 % DEPTH];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] v);
    mem0[tail0 % DEPTH] = v;
    tail0 = tail0 + 1;
  endtask

  task automatic push1(input logic [7:0] v);
    mem1[tail1 % DEPTH] = v;
    tail1 = tail1 + 1;
  endtask

  task automatic drain(input string name, input int limit);
    int i = 0;
    while (!(fifo0_empty && fifo1_empty) && i < limit) begin
      tick();
      i++;
    end
    check(i < limit, {name, "_drain"}, i, limit);
    repeat (4) tick();
  endtask

  // Expected output order for a preloaded backlog (n0, n1) right after reset:
  // channels alternate in quanta of W0/W1; a FIFO that runs dry inside its
  // quantum costs one idle cycle before the other channel starts.
  task automatic check_sched(input string name, input int base, input int n0, input int n1,
                             input logic [7:0] b0, input logic [7:0] b1, input bit gaps);
    bit         es_src [$];
    bit         es_bub [$];
    int         n [2];
    int         w [2];
    int         cur, k, k0, k1, ag, eg;
    bit         bub;
    logic [9:0] ew;
    n[0] = n0; n[1] = n1; w[0] = W0; w[1] = W1;
    cur = (n0 > 0) ? 0 : 1;
    bub = 0;
    while (n[0] + n[1] > 0) begin
      k = (n[cur] < w[cur]) ? n[cur] : w[cur];
      for (int i = 0; i < k; i++) begin
        es_src.push_back(cur[0]);
        es_bub.push_back(bub);
        bub = 0;
      end
      n[cur] -= k;
      if (k < w[cur]) bub = 1;
      if (n[1 - cur] > 0) cur = 1 - cur;
    end
    check(rec_word.size() - base == es_src.size(), {name, "_len"},
          rec_word.size() - base, es_src.size());
    k0 = 0; k1 = 0;
    for (int i = 0; i < es_src.size() && base + i < rec_word.size(); i++) begin
      if (es_src[i]) begin ew = {1'b1, 1'b1, 8'(b1 + k1)}; k1++; end
      else           begin ew = {1'b1, 1'b0, 8'(b0 + k0)}; k0++; end
      eg = es_bub[i] ? 1 : 0;
      ag = (i == 0) ? 0 : rec_cyc[base + i] - rec_cyc[base + i - 1] - 1;
      if (!gaps) ag = eg;
      check(rec_word[base + i] == ew && ag == eg, {name, "_seq"},
            (32'(ag) << 16) | 32'(rec_word[base + i]), (32'(eg) << 16) | 32'(ew));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base, n, cntv;
    logic [23:0] pat;
    logic [4:0]  ov;

    // Reset held with both FIFOs loaded, then fairness run with W0=4, W1=2.
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push0(8'(i));
      push1(8'(8'h80 + i));
    end
    repeat (3) tick();
    check(!fifo0_pop && !fifo1_pop, "hold_pops", {fifo1_pop, fifo0_pop}, 0);
    check(out_valid == 1'b0 && cnt0 == 16'd0 && cnt1 == 16'd0, "hold_outs",
          {out_valid, cnt1, cnt0}, 0);
    base = rec_word.size();
    rec_en = 1'b1;
    reset = 1'b1;
    check(!fifo0_pop && !fifo1_pop, "release_idle", {fifo1_pop, fifo0_pop}, 0);
    tick();
    check(fifo0_pop && !fifo1_pop, "first_pop", {fifo1_pop, fifo0_pop}, 2'b01);
    drain("fair", 200);
    rec_en = 1'b0;
    check_sched("fair", base, 12, 12, 8'h00, 8'h80, 1'b1);
    pat = '0;
    if (rec_word.size() >= base + 24)
      for (int i = 0; i < 24; i++) pat = {pat[22:0], rec_word[base + i][8]};
    check(pat == 24'h0C30FF, "fair_pattern", pat, 24'h0C30FF);
    check(cnt0 == 16'd12 && cnt1 == 16'd12, "fair_cnt", {cnt1, cnt0}, {16'd12, 16'd12});

    // Single source on channel 1 across quantum boundaries.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push1(8'(8'hA0 + i));
    repeat (2) tick();
    base = rec_word.size();
    rec_en = 1'b1;
    reset = 1'b1;
    drain("single", 100);
    rec_en = 1'b0;
    check_sched("single", base, 0, 5, 8'h00, 8'hA0, 1'b1);
    for (int i = 0; i < 5 && base + i < rec_word.size(); i++) begin
      check(rec_word[base + i] == 10'(10'h3A0 + i), "single_word", rec_word[base + i], 10'h3A0 + i);
      if (i > 0)
        check(rec_cyc[base + i] - rec_cyc[base + i - 1] == 1, "single_contig",
              rec_cyc[base + i] - rec_cyc[base + i - 1], 1);
    end

    // Pause for 3 cycles after two channel-0 pops.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push0(8'(8'h10 + i));
      push1(8'(8'h90 + i));
    end
    repeat (2) tick();
    base = rec_word.size();
    rec_en = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    pause_in = 1'b1;
    ov = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) pause_in = 1'b0;
      ov[i] = out_valid;
    end
    check(ov == 5'b10001, "pause_valid", ov, 5'b10001);
    drain("pause", 100);
    rec_en = 1'b0;
    check_sched("pause", base, 6, 6, 8'h10, 8'h90, 1'b0);

    // Channel 0 runs dry inside its quantum.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) push0(8'(8'h20 + i));
    for (int i = 0; i < 3; i++) push1(8'(8'hB0 + i));
    repeat (2) tick();
    base = rec_word.size();
    rec_en = 1'b1;
    reset = 1'b1;
    drain("dry", 100);
    rec_en = 1'b0;
    check_sched("dry", base, 2, 3, 8'h20, 8'hB0, 1'b1);
    if (rec_word.size() >= base + 3)
      check(rec_cyc[base + 2] - rec_cyc[base + 1] == 2, "dry_bubble",
            rec_cyc[base + 2] - rec_cyc[base + 1], 2);

    // Reset in the cycle after a pop: that word never appears.
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    push0(8'h5A);
    n = 0;
    while (!fifo0_pop && n < 20) begin
      tick();
      n++;
    end
    check(n < 20, "midrst_pop_wait", n, 20);
    tick();
    reset = 1'b0;
    cntv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) reset = 1'b1;
      cntv += int'(out_valid);
    end
    check(cntv == 0, "midrst_no_valid", cntv, 0);

    // Randomized traffic, pause and occasional reset pulses.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 45 && tail0 - head0 < 16) push0(8'($urandom));
      if ($urandom_range(0, 99) < 35 && tail1 - head1 < 16) push1(8'($urandom));
      pause_in = ($urandom_range(0, 99) < 15);
      reset = ($urandom_range(0, 999) != 0);
      tick();
    end
    reset = 1'b1;
    pause_in = 1'b0;
    drain("rand", 200);

    // Counter wrap: 65535 words, then one more.
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 70000 && n < 65535; i++) begin
      if (tail0 - head0 < 4) begin
        push0(8'(n));
        n++;
      end
      tick();
    end
    check(n == 65535, "wrap_pushed", n, 65535);
    drain("wrap", 100);
    check(cnt0 == 16'hFFFF, "cnt0_full", cnt0, 16'hFFFF);
    push0(8'hEE);
    drain("wrap2", 50);
    check(cnt0 == 16'h0000, "cnt0_wrap", cnt0, 16'h0000);
    check(cnt1 == 16'h0000, "cnt1_after_wrap", cnt1, 16'h0000);
    check(out_word == 10'h2EE, "wrap_word", out_word, 10'h2EE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
